// File: rtl/cfg_chain_loader_pkg.sv
// Shared definitions for the configuration chain loader:
// FSM state encodings and the bitstream byte width.
package cfg_chain_loader_pkg;

    localparam int CFG_BYTE_W = 8;

    typedef enum logic [1:0] {
        CFG_IDLE = 2'd0,
        CFG_LOAD = 2'd1,
        CFG_DONE = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/cfg_byte_serializer.sv
// Double-buffered byte serializer: hold reg feeding a shift reg, MSB first.
// Ports: clk, rst (async, high), flush (sync clear),
//        load_valid/load_ready/byte_in (byte side),
//        bit_ready/bit_out/bit_valid (bit side; a bit is taken when valid&&ready).
module cfg_byte_serializer
    import cfg_chain_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [CFG_BYTE_W-1:0] byte_in,
    input  logic                  bit_ready,
    output logic                  bit_out,
    output logic                  bit_valid
);

    localparam logic [3:0] CNT_FULL = 4'(CFG_BYTE_W);
    localparam logic [3:0] CNT_REST = 4'(CFG_BYTE_W - 1);

    logic [CFG_BYTE_W-1:0] hold_data;
    logic                  hold_full;
    logic [CFG_BYTE_W-1:0] sh_data;
    logic [3:0]            sh_cnt;
    logic                  take;
    logic                  direct;

    assign load_ready = !hold_full;

    // Next bit comes from the shift reg, else the hold reg, else straight
    // from an incoming byte, so an empty loader adds no extra cycle.
    always_comb begin
        bit_out   = 1'b0;
        bit_valid = 1'b0;
        if (sh_cnt != 4'd0) begin
            bit_out   = sh_data[CFG_BYTE_W-1];
            bit_valid = 1'b1;
        end else if (hold_full) begin
            bit_out   = hold_data[CFG_BYTE_W-1];
            bit_valid = 1'b1;
        end else if (load_valid) begin
            bit_out   = byte_in[CFG_BYTE_W-1];
            bit_valid = 1'b1;
        end
    end

    assign take = bit_valid && bit_ready;

    // Incoming byte bypasses the hold reg when the shift reg is empty
    // or on its final bit and nothing is waiting in the hold reg.
    assign direct = take && !hold_full && (sh_cnt <= 4'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            sh_data   <= '0;
            sh_cnt    <= 4'd0;
        end else if (flush) begin
            hold_full <= 1'b0;
            sh_cnt    <= 4'd0;
        end else begin
            if (take) begin
                if (sh_cnt > 4'd1) begin
                    sh_data <= sh_data << 1;
                    sh_cnt  <= sh_cnt - 4'd1;
                end else if (sh_cnt == 4'd1 && hold_full) begin
                    sh_data   <= hold_data;
                    sh_cnt    <= CNT_FULL;
                    hold_full <= 1'b0;
                end else if (sh_cnt == 4'd1 && load_valid) begin
                    sh_data <= byte_in;
                    sh_cnt  <= CNT_FULL;
                end else if (sh_cnt == 4'd1) begin
                    sh_cnt <= 4'd0;
                end else if (hold_full) begin
                    sh_data   <= hold_data << 1;
                    sh_cnt    <= CNT_REST;
                    hold_full <= 1'b0;
                end else begin
                    sh_data <= byte_in << 1;
                    sh_cnt  <= CNT_REST;
                end
            end
            if (load_valid && !direct) begin
                hold_data <= byte_in;
                hold_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_chain_loader.sv
// Streams a bitstream byte by byte into the fabric config chain (ccff).
// Ports: prog_clk, pReset (async, high), start, s_valid/s_ready/s_data
//        (byte stream), ccff_head/shift_en (chain drive, registered),
//        busy, done, bit_count (bits shifted in this load).
module cfg_chain_loader
    import cfg_chain_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 256,
    parameter int CNT_W     = 16
) (
    input  logic                  prog_clk,
    input  logic                  pReset,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [CFG_BYTE_W-1:0] s_data,
    output logic                  ccff_head,
    output logic                  shift_en,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      bit_count
);

    localparam logic [CNT_W:0] LEN = (CNT_W + 1)'(CHAIN_LEN);

    cfg_state_t     state;
    logic           load_ready;
    logic           bit_out;
    logic           bit_valid;
    logic           bit_ready;
    logic           go;
    logic           last;
    logic           flush;
    logic [CNT_W:0] issued;

    assign go = start && (state != CFG_LOAD);

    // Bits already handed to the chain, including the one on ccff_head now.
    assign issued = {1'b0, bit_count} + {{CNT_W{1'b0}}, shift_en};

    assign last = (state == CFG_LOAD) && shift_en
               && ({1'b0, bit_count} + (CNT_W + 1)'(1) == LEN);

    // Stop pulling bits once CHAIN_LEN are issued; leftovers are flushed.
    assign bit_ready = (state == CFG_LOAD) && (issued < LEN);
    assign flush     = go || last;
    assign s_ready   = (state == CFG_LOAD) && load_ready;

    cfg_byte_serializer u_ser (
        .clk        (prog_clk),
        .rst        (pReset),
        .flush      (flush),
        .load_valid (s_valid && s_ready),
        .load_ready (load_ready),
        .byte_in    (s_data),
        .bit_ready  (bit_ready),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid)
    );

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state     <= CFG_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            bit_count <= '0;
            shift_en  <= 1'b0;
            ccff_head <= 1'b0;
        end else begin
            shift_en <= 1'b0;
            unique case (state)
                CFG_IDLE, CFG_DONE: begin
                    if (go) begin
                        state     <= CFG_LOAD;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        bit_count <= '0;
                    end
                end
                CFG_LOAD: begin
                    if (shift_en) begin
                        bit_count <= bit_count + CNT_W'(1);
                    end
                    if (last) begin
                        state <= CFG_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (bit_valid && bit_ready) begin
                        shift_en  <= 1'b1;
                        ccff_head <= bit_out;
                    end
                end
                default: state <= CFG_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Self-checking bench for cfg_chain_loader: three instances with
// CHAIN_LEN 16, 12 and 256, directed and randomized loads.
module tb_cfg_chain_loader;

    localparam int LENS[3] = '{16, 12, 256};

    logic        clk = 1'b0;
    logic        rst;
    logic        start[3];
    logic        s_valid[3];
    logic [7:0]  s_data[3];
    logic        s_ready[3];
    logic        ccff_head[3];
    logic        shift_en[3];
    logic        busy[3];
    logic        done[3];
    logic [15:0] bit_count[3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cfg_chain_loader #(
            .CHAIN_LEN (LENS[g]),
            .CNT_W     (16)
        ) dut (
            .prog_clk  (clk),
            .pReset    (rst),
            .start     (start[g]),
            .s_valid   (s_valid[g]),
            .s_ready   (s_ready[g]),
            .s_data    (s_data[g]),
            .ccff_head (ccff_head[g]),
            .shift_en  (shift_en[g]),
            .busy      (busy[g]),
            .done      (done[g]),
            .bit_count (bit_count[g])
        );
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] byte_q[$];
    logic       got_q[$];
    int         gap_at;
    int         gap_len;
    int         busy_start_bit;
    int         abort_bits;
    bit         rnd_gaps;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input bit rg, input int gat, input int glen,
                         input int bsb, input int ab);
        rnd_gaps       = rg;
        gap_at         = gat;
        gap_len        = glen;
        busy_start_bit = bsb;
        abort_bits     = ab;
    endtask

    task automatic rand_bytes(input int n);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(8'($urandom));
    endtask

    task automatic chk_zero(input int idx, input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready[idx]), 0);
        chk({tag, "_ccff_head"}, 32'(ccff_head[idx]), 0);
        chk({tag, "_shift_en"}, 32'(shift_en[idx]), 0);
        chk({tag, "_busy"}, 32'(busy[idx]), 0);
        chk({tag, "_done"}, 32'(done[idx]), 0);
        chk({tag, "_bit_count"}, 32'(bit_count[idx]), 0);
    endtask

    task automatic do_start(input int idx);
        start[idx] = 1'b1;
        @(negedge clk);
        start[idx] = 1'b0;
        chk("start_busy", 32'(busy[idx]), 1);
        chk("start_done_clear", 32'(done[idx]), 0);
        chk("start_bit_count", 32'(bit_count[idx]), 0);
        chk("start_shift_en", 32'(shift_en[idx]), 0);
        chk("start_s_ready", 32'(s_ready[idx]), 1);
    endtask

    // Drives byte_q into instance idx and compares what reaches the chain
    // against the first CHAIN_LEN bits of byte_q, MSB first.
    task automatic run_stream(input int idx, output int stall);
        int          len = LENS[idx];
        int          ptr = 0;
        int          cyc = 0;
        int          first = -1;
        int          last = -1;
        int          gapc = 0;
        int          done_cyc = -1;
        int          mism = 0;
        bit          injected = 0;
        bit          fin = 0;
        logic [15:0] prev_cnt;
        logic        prev_se;
        got_q.delete();
        prev_cnt = bit_count[idx];
        prev_se  = shift_en[idx];
        while (!fin && cyc < 4000) begin
            start[idx] = 1'b0;
            if (busy_start_bit >= 0 && !injected
                && int'(bit_count[idx]) == busy_start_bit) begin
                start[idx] = 1'b1;
                injected   = 1;
            end
            s_valid[idx] = 1'b0;
            s_data[idx]  = 8'($urandom);
            if (ptr < byte_q.size()) begin
                if (gapc > 0) begin
                    gapc--;
                end else if (!(rnd_gaps && $urandom_range(0, 3) == 0)) begin
                    s_valid[idx] = 1'b1;
                    s_data[idx]  = byte_q[ptr];
                end
            end
            if (s_valid[idx] && s_ready[idx]) begin
                if (ptr == gap_at) gapc = gap_len;
                ptr++;
            end
            @(negedge clk);
            cyc++;
            chk("bit_count_step", 32'(bit_count[idx]),
                32'(prev_cnt) + 32'(prev_se));
            if (shift_en[idx]) begin
                got_q.push_back(ccff_head[idx]);
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (done[idx]) begin
                done_cyc = cyc;
                fin      = 1;
            end else if (abort_bits > 0 && got_q.size() == abort_bits) begin
                fin = 1;
            end
            prev_cnt = bit_count[idx];
            prev_se  = shift_en[idx];
        end
        start[idx] = 1'b0;
        chk("load_finished", 32'(fin), 1);
        for (int i = 0; i < got_q.size(); i++) begin
            if (i >= len || got_q[i] !== byte_q[i / 8][7 - (i % 8)]) mism++;
        end
        chk("bit_stream", 32'(mism), 0);
        stall = (last - first + 1) - got_q.size();
        if (abort_bits > 0) return;
        chk("pulse_count", 32'(got_q.size()), 32'(len));
        chk("done_latency", 32'(done_cyc), 32'(last + 1));
        chk("final_bit_count", 32'(bit_count[idx]), 32'(len));
        chk("final_busy", 32'(busy[idx]), 0);
        chk("final_s_ready", 32'(s_ready[idx]), 0);
        for (int i = 0; i < 3; i++) begin
            s_valid[idx] = 1'b1;
            s_data[idx]  = 8'($urandom);
            @(negedge clk);
        end
        s_valid[idx] = 1'b0;
        chk("post_s_ready", 32'(s_ready[idx]), 0);
        chk("post_shift_en", 32'(shift_en[idx]), 0);
        chk("post_done", 32'(done[idx]), 1);
        chk("post_bit_count", 32'(bit_count[idx]), 32'(len));
    endtask

    initial begin
        int stall;
        int nz;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start[i]   = 1'b0;
            s_valid[i] = 1'b0;
            s_data[i]  = 8'h00;
        end
        setup(0, -1, 0, -1, 0);

        // async reset with no clock edge
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) chk_zero(i, "reset_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nz = 0;
        repeat (20) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (s_ready[i] !== 1'b0 || busy[i] !== 1'b0) nz++;
            end
        end
        chk("idle_no_ready", 32'(nz), 0);

        // 16-bit chain, back-to-back bytes
        byte_q = '{8'hA5, 8'h3C};
        setup(0, -1, 0, -1, 0);
        do_start(0);
        run_stream(0, stall);
        chk("b2b_no_stall_16", 32'(stall), 0);

        // 12-bit chain, partial final byte, extra byte discarded
        byte_q = '{8'hA5, 8'h3C, 8'hFF};
        do_start(1);
        run_stream(1, stall);
        chk("b2b_no_stall_12", 32'(stall), 0);

        // underflow: stream stalls 5 cycles beyond the first byte's shifts
        byte_q = '{8'hF0, 8'h0F};
        setup(0, 0, 12, -1, 0);
        do_start(0);
        run_stream(0, stall);
        chk("underflow_gap", 32'(stall), 5);

        // start while busy at bit 5 is ignored
        rand_bytes(2);
        setup(0, -1, 0, 5, 0);
        do_start(0);
        run_stream(0, stall);

        // reset mid-load on the 256-bit chain after 37 bits
        rand_bytes(32);
        setup(1, -1, 0, -1, 37);
        do_start(2);
        run_stream(2, stall);
        s_valid[2] = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk_zero(2, "reset_mid_load");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero(2, "after_reset");
        setup(1, -1, 0, -1, 0);
        do_start(2);
        run_stream(2, stall);

        // randomized loads; each restart comes from DONE
        for (int k = 0; k < 4; k++) begin
            rand_bytes(2 + (k % 2));
            setup(1, -1, 0, -1, 0);
            do_start(1);
            run_stream(1, stall);
            rand_bytes(2);
            do_start(0);
            run_stream(0, stall);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
